// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/ack port and a {pc, word} FIFO toward decode.
// Define FETCH_STATS_EN to add the fetch_count / stall_count statistics counters.
module fetch_unit #(
  parameter int unsigned       ADDR_W     = 28,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_address,
  output logic              imem_readEn,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int unsigned       PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned       CntW     = PtrW + 1;
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);
  localparam logic [CntW-1:0]   Depth    = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0]   LastSlot = CntW'(FIFO_DEPTH - 1);
  localparam logic [PtrW-1:0]   PtrOne   = PtrW'(1);
  localparam logic [ADDR_W-1:0] Step     = ADDR_W'(4);

  typedef enum logic [1:0] {StIdle, StReq, StFull, StDrop} state_e;

  state_e            state;
  logic              read_en;
  logic [ADDR_W-1:0] pc, req_addr, target, next_addr;
  logic [CntW-1:0]   count;
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic              push, pop;

  assign target       = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign next_addr    = req_addr + Step;
  assign pop          = inst_valid & inst_ready;
  // An ack in the redirect cycle belongs to the old path and is discarded.
  assign push         = (state == StReq) & imem_ack & ~redirect;
  assign inst_valid   = (count != '0);
  assign inst_data    = inst_valid ? data_mem[rd_ptr] : '0;
  assign inst_pc      = inst_valid ? pc_mem[rd_ptr] : '0;
  assign imem_address = req_addr;
  assign imem_readEn  = read_en;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_addr;
      data_mem[wr_ptr] <= imem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      read_en  <= 1'b0;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PtrOne;
        if (pop) rd_ptr <= rd_ptr + PtrOne;
        if (push && !pop) count <= count + CntOne;
        else if (!push && pop) count <= count - CntOne;
      end

      unique case (state)
        StIdle: begin
          state   <= StReq;
          read_en <= 1'b1;
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
          end
        end
        StReq: begin
          if (redirect) begin
            pc <= target;
            // Without an ack the request must stay stable until the memory answers.
            if (imem_ack) req_addr <= target;
            else state <= StDrop;
          end else if (imem_ack) begin
            pc       <= next_addr;
            req_addr <= next_addr;
            if (count == LastSlot && !pop) begin
              state   <= StFull;
              read_en <= 1'b0;
            end
          end
        end
        StFull: begin
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
            state    <= StReq;
            read_en  <= 1'b1;
          end else if (count < Depth) begin
            req_addr <= pc;
            state    <= StReq;
            read_en  <= 1'b1;
          end
        end
        StDrop: begin
          if (redirect) pc <= target;
          if (imem_ack) begin
            req_addr <= redirect ? target : pc;
            state    <= StReq;
          end
        end
        default: begin
          state   <= StIdle;
          read_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push) fetch_count <= fetch_count + 32'd1;
      if (inst_valid && !inst_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected pcs, monitors pop and compare.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [27:0] imem_address, w_address;
  logic        imem_readEn, w_readEn;
  logic        imem_ack, w_ack;
  logic [31:0] imem_data, w_data;
  logic        redirect;
  logic [27:0] redirect_pc;
  logic        inst_valid, w_valid;
  logic        inst_ready, ready2;
  logic [31:0] inst_data, w_inst_data;
  logic [27:0] inst_pc, w_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          lat = 0;
  int          wait_cnt;
  logic [27:0] exp_q[$];
  logic [27:0] exp2_q[$];
  logic [27:0] e1, e2;

  fetch_unit #(.ADDR_W(28), .RESET_PC(28'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_address(imem_address), .imem_readEn(imem_readEn),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  fetch_unit #(.ADDR_W(28), .RESET_PC(28'hFFFFFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_address(w_address), .imem_readEn(w_readEn),
    .imem_ack(w_ack), .imem_data(w_data),
    .redirect(1'b0), .redirect_pc(28'h0),
    .inst_valid(w_valid), .inst_ready(ready2),
    .inst_data(w_inst_data), .inst_pc(w_pc)
`ifdef FETCH_STATS_EN
    , .fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [27:0] a);
    return {a, 4'h3} ^ 32'h5A5A_0000;
  endfunction

  // Memory models: dut answers after `lat` wait cycles, dut_wrap answers in the same cycle.
  assign imem_ack  = imem_readEn && (wait_cnt >= lat);
  assign imem_data = word_at(imem_address);
  assign w_ack     = w_readEn;
  assign w_data    = word_at(w_address);

  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 0;
    else if (imem_readEn && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", {4'h0, inst_pc}, 32'hFFFF_FFFF);
      end else begin
        e1 = exp_q.pop_front();
        chk("pop_pc", {4'h0, inst_pc}, {4'h0, e1});
        chk("pop_data", inst_data, word_at(e1));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && w_valid && ready2) begin
      if (exp2_q.size() == 0) begin
        chk("wrap_unexpected_pop_pc", {4'h0, w_pc}, 32'hFFFF_FFFF);
      end else begin
        e2 = exp2_q.pop_front();
        chk("wrap_pop_pc", {4'h0, w_pc}, {4'h0, e2});
        chk("wrap_pop_data", w_inst_data, word_at(e2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 (first cycle with rst released).
  task automatic do_reset();
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0; ready2 = 1'b0;
    exp_q.delete(); exp2_q.delete();
    tick(); tick();
    @(negedge clk);
    chk("rst_readEn", {31'h0, imem_readEn}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", {4'h0, inst_pc}, 32'h0);
    chk("rst_wrap_readEn", {31'h0, w_readEn}, 32'h0);
    tick();
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (exp_q.size() == 0 && exp2_q.size() == 0) break;
    end
    inst_ready = 1'b0; ready2 = 1'b0;
    chk(name, 32'(exp_q.size() + exp2_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0; ready2 = 1'b0;

    // Streaming with same-cycle ack and ready held high.
    lat = 0;
    do_reset();
    inst_ready = 1'b1;
    exp_q.push_back(28'h0); exp_q.push_back(28'h4); exp_q.push_back(28'h8);
    @(negedge clk); chk("s1_c0_readEn", {31'h0, imem_readEn}, 32'h0);
    tick(); @(negedge clk);
    chk("s1_c1_readEn", {31'h0, imem_readEn}, 32'h1);
    chk("s1_c1_addr", {4'h0, imem_address}, 32'h0);
    for (int c = 2; c <= 4; c++) begin
      tick(); @(negedge clk);
      chk("s1_no_gap_valid", {31'h0, inst_valid}, 32'h1);
    end
    drain("s1_drain");

    // Decode stalled from the start: FIFO fills, fetch stops, then resumes in order.
    do_reset();
    tick(); tick(); tick(); @(negedge clk);
    chk("s2_full_readEn", {31'h0, imem_readEn}, 32'h0);
    chk("s2_full_valid", {31'h0, inst_valid}, 32'h1);
    chk("s2_full_pc", {4'h0, inst_pc}, 32'h0);
    tick(); tick(); @(negedge clk);
    chk("s2_hold_readEn", {31'h0, imem_readEn}, 32'h0);
    chk("s2_hold_pc", {4'h0, inst_pc}, 32'h0);
    tick();
    inst_ready = 1'b1;
    exp_q.push_back(28'h0); exp_q.push_back(28'h4); exp_q.push_back(28'h8);
    drain("s2_drain");

    // Slow memory, redirect while the request to 0x8 is outstanding.
    lat = 3;
    do_reset();
    inst_ready = 1'b1;
    exp_q.push_back(28'h0); exp_q.push_back(28'h4); exp_q.push_back(28'h100);
    for (int i = 0; i < 40; i++) begin
      if (imem_readEn && imem_address == 28'h8) break;
      tick();
    end
    chk("s3_req8_seen", {31'h0, imem_readEn && imem_address == 28'h8}, 32'h1);
    tick();
    redirect = 1'b1; redirect_pc = 28'h100;
    @(negedge clk); chk("s3_no_ack_at_redirect", {31'h0, imem_ack}, 32'h0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("s3_drop_addr_held", {4'h0, imem_address}, 32'h8);
    for (int i = 0; i < 20; i++) begin
      if (imem_ack) break;
      tick();
    end
    chk("s3_drop_ack_seen", {31'h0, imem_ack}, 32'h1);
    tick(); @(negedge clk);
    chk("s3_target_readEn", {31'h0, imem_readEn}, 32'h1);
    chk("s3_target_addr", {4'h0, imem_address}, 32'h100);
    drain("s3_drain");

    // Redirect coinciding with an ack and a pop; target low bits are forced to zero.
    lat = 0;
    do_reset();
    inst_ready = 1'b1;
    exp_q.push_back(28'h0); exp_q.push_back(28'h40);
    tick(); tick();
    redirect = 1'b1; redirect_pc = 28'h43;
    @(negedge clk);
    chk("s4_ack_at_redirect", {31'h0, imem_ack}, 32'h1);
    chk("s4_valid_at_redirect", {31'h0, inst_valid}, 32'h1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("s4_flushed_valid", {31'h0, inst_valid}, 32'h0);
    chk("s4_target_addr", {4'h0, imem_address}, 32'h40);
    chk("s4_target_readEn", {31'h0, imem_readEn}, 32'h1);
    drain("s4_drain");

    // Address wrap from RESET_PC near the top of the space.
    do_reset();
    ready2 = 1'b1;
    exp2_q.push_back(28'hFFFFFF8); exp2_q.push_back(28'hFFFFFFC); exp2_q.push_back(28'h0);
    drain("s5_drain");

    // Reset asserted while a dropped request is outstanding.
    lat = 3;
    do_reset();
    tick(); tick();
    redirect = 1'b1; redirect_pc = 28'h80;
    @(negedge clk); chk("s6_no_ack_at_redirect", {31'h0, imem_ack}, 32'h0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("s6_drop_readEn", {31'h0, imem_readEn}, 32'h1);
    rst = 1'b0;
    #1;
    chk("s6_async_readEn", {31'h0, imem_readEn}, 32'h0);
    chk("s6_async_addr", {4'h0, imem_address}, 32'h0);
    tick(); tick();
    rst = 1'b1;
    @(negedge clk); chk("s6_c0_readEn", {31'h0, imem_readEn}, 32'h0);
    tick(); @(negedge clk);
    chk("s6_c1_readEn", {31'h0, imem_readEn}, 32'h1);
    chk("s6_c1_addr", {4'h0, imem_address}, 32'h0);
    inst_ready = 1'b1;
    exp_q.push_back(28'h0);
    drain("s6_drain");

`ifdef FETCH_STATS_EN
    // Four stall cycles (2..5), then pops from cycle 6; ten pushes by the end of cycle 15.
    lat = 0;
    do_reset();
    repeat (5) tick();
    tick();
    inst_ready = 1'b1;
    for (int k = 0; k <= 10; k++) exp_q.push_back(28'(4 * k));
    repeat (10) tick();
    @(negedge clk);
    chk("stats_fetch_count", fetch_count, 32'd10);
    chk("stats_stall_count", stall_count, 32'd4);
    drain("s7_drain");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
